// File: rtl/flag_register_if.sv
// Bus between the 8088 execution unit decode/ALU/stack paths and the FLAGS register.
// The master drives strobes and load data; the slave (flag_register) returns FLAGS state.
interface flag_register_if;
  logic        RSTCF;
  logic        RSTDF;
  logic        RSTIF;
  logic        SETCF;
  logic        SETDF;
  logic        SETIF;
  logic        TOGCF;
  logic        alu_we;
  logic [5:0]  alu_mask;
  logic [5:0]  alu_flags;
  logic        sahf_we;
  logic [7:0]  ah_in;
  logic        popf_we;
  logic [15:0] popf_data;
  logic        int_ack;
  logic        instr_done;
  logic [15:0] flags;
  logic        int_enable;
  logic        trap_req;

  modport master (
    output RSTCF, RSTDF, RSTIF, SETCF, SETDF, SETIF, TOGCF,
    output alu_we, alu_mask, alu_flags, sahf_we, ah_in, popf_we, popf_data,
    output int_ack, instr_done,
    input  flags, int_enable, trap_req
  );

  modport slave (
    input  RSTCF, RSTDF, RSTIF, SETCF, SETDF, SETIF, TOGCF,
    input  alu_we, alu_mask, alu_flags, sahf_we, ah_in, popf_we, popf_data,
    input  int_ack, instr_done,
    output flags, int_enable, trap_req
  );
endinterface

// File: rtl/flag_register.sv
// 8088 architectural FLAGS register with STI interrupt shadow and single-step trap.
// Optional macro FLAGS_STI_SHADOW_EN enables the one-instruction STI shadow FSM.
module flag_register (
  input  logic             clk,
  input  logic             rst_n,
  flag_register_if.slave   bus
);

  localparam int unsigned CfBit = 0;
  localparam int unsigned TfBit = 8;
  localparam int unsigned IfBit = 9;
  localparam int unsigned DfBit = 10;
  localparam int unsigned OfBit = 11;
  localparam logic [15:0] ResetVal = 16'hF002;

  // FLAGS positions of alu bits 1..4 (PF, AF, ZF, SF); these share SAHF's AH bit positions.
  localparam int unsigned StatPos [4] = '{2, 4, 6, 7};

  logic [15:0] flags_q, flags_d;
  logic        tf_armed_q;
  logic        int_enable;

  // Per-flag priority chains; reserved bits are never written so they keep their reset value.
  always_comb begin
    flags_d = flags_q;

    if (bus.popf_we)                       flags_d[CfBit] = bus.popf_data[CfBit];
    else if (bus.sahf_we)                  flags_d[CfBit] = bus.ah_in[CfBit];
    else if (bus.TOGCF)                    flags_d[CfBit] = ~flags_q[CfBit];
    else if (bus.SETCF)                    flags_d[CfBit] = 1'b1;
    else if (bus.RSTCF)                    flags_d[CfBit] = 1'b0;
    else if (bus.alu_we && bus.alu_mask[0]) flags_d[CfBit] = bus.alu_flags[0];

    for (int i = 1; i < 5; i++) begin
      if (bus.popf_we)                       flags_d[StatPos[i-1]] = bus.popf_data[StatPos[i-1]];
      else if (bus.sahf_we)                  flags_d[StatPos[i-1]] = bus.ah_in[StatPos[i-1]];
      else if (bus.alu_we && bus.alu_mask[i]) flags_d[StatPos[i-1]] = bus.alu_flags[i];
    end

    if (bus.popf_we)                        flags_d[OfBit] = bus.popf_data[OfBit];
    else if (bus.alu_we && bus.alu_mask[5]) flags_d[OfBit] = bus.alu_flags[5];

    if (bus.int_ack)      flags_d[TfBit] = 1'b0;
    else if (bus.popf_we) flags_d[TfBit] = bus.popf_data[TfBit];

    if (bus.int_ack)      flags_d[IfBit] = 1'b0;
    else if (bus.popf_we) flags_d[IfBit] = bus.popf_data[IfBit];
    else if (bus.SETIF)   flags_d[IfBit] = 1'b1;
    else if (bus.RSTIF)   flags_d[IfBit] = 1'b0;

    if (bus.popf_we)      flags_d[DfBit] = bus.popf_data[DfBit];
    else if (bus.SETDF)   flags_d[DfBit] = 1'b1;
    else if (bus.RSTDF)   flags_d[DfBit] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= ResetVal;
    end else begin
      flags_q <= flags_d;
    end
  end

  // TF is sampled at each boundary so the instruction that sets TF does not itself trap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tf_armed_q <= 1'b0;
    end else if (bus.int_ack) begin
      tf_armed_q <= 1'b0;
    end else if (bus.instr_done) begin
      tf_armed_q <= flags_q[TfBit];
    end
  end

`ifdef FLAGS_STI_SHADOW_EN
  typedef enum logic {StIdle, StShadow} sti_state_e;

  sti_state_e state_q, state_d;
  logic       sti_accept;

  assign sti_accept = bus.SETIF && !bus.int_ack && !bus.popf_we;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (sti_accept && !flags_q[IfBit]) state_d = StShadow;
      end
      StShadow: begin
        // Any boundary seen while in StShadow is necessarily after the entry cycle.
        if (bus.instr_done || bus.RSTIF || bus.int_ack || bus.popf_we) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign int_enable = flags_q[IfBit] && (state_q == StIdle);
`else
  assign int_enable = flags_q[IfBit];
`endif

  assign bus.flags      = flags_q;
  assign bus.int_enable = int_enable;
  assign bus.trap_req   = bus.instr_done & tf_armed_q;

  // Reserved bit positions of the load paths are intentionally ignored.
  logic unused_load_bits;
  assign unused_load_bits = ^{bus.ah_in[5], bus.ah_in[3], bus.ah_in[1],
                              bus.popf_data[15:12], bus.popf_data[5], bus.popf_data[3],
                              bus.popf_data[1]};

endmodule

// File: tb/tb_flag_register.sv
// Scoreboard bench for flag_register: stimulus pushes expected outputs from a reference
// model; a negedge monitor pops and compares. Honours FLAGS_STI_SHADOW_EN.
module tb_flag_register;

  typedef struct packed {
    logic        rstcf, rstdf, rstif, setcf, setdf, setif, togcf;
    logic        alu_we;
    logic [5:0]  alu_mask;
    logic [5:0]  alu_flags;
    logic        sahf_we;
    logic [7:0]  ah;
    logic        popf_we;
    logic [15:0] popf_data;
    logic        int_ack;
    logic        instr_done;
  } stim_t;

  typedef struct packed {
    logic [15:0] flags;
    logic        ie;
    logic        trap;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  flag_register_if bus ();

  flag_register dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: architectural FLAGS, shadow-pending, and armed single-step.
  logic [15:0] m_flags;
  bit          m_shadow;
  bit          m_armed;

  function automatic stim_t z();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Sources applied lowest priority first; each later source overwrites what it owns.
  function automatic logic [15:0] model_next(input stim_t s, input logic [15:0] f);
    logic [15:0] n;
    int          alu_pos [6];
    alu_pos = '{0, 2, 4, 6, 7, 11};
    n = f;
    if (s.alu_we)
      for (int i = 0; i < 6; i++)
        if (s.alu_mask[i]) n[alu_pos[i]] = s.alu_flags[i];
    if (s.togcf)      n[0] = ~f[0];
    else if (s.setcf) n[0] = 1'b1;
    else if (s.rstcf) n[0] = 1'b0;
    if (s.setdf)      n[10] = 1'b1;
    else if (s.rstdf) n[10] = 1'b0;
    if (s.setif)      n[9] = 1'b1;
    else if (s.rstif) n[9] = 1'b0;
    if (s.sahf_we) n = (n & ~16'h00D5) | ({8'h00, s.ah} & 16'h00D5);
    if (s.popf_we) n = (n & ~16'h0FD5) | (s.popf_data & 16'h0FD5);
    if (s.int_ack) begin
      n[9] = 1'b0;
      n[8] = 1'b0;
    end
    return (n & 16'h0FD5) | 16'hF002;
  endfunction

  task automatic apply(input stim_t s, input logic rst);
    exp_t        e;
    logic [15:0] nf;
    bit          nshadow, narmed;
    @(posedge clk);
    #1;
    rst_n          = rst;
    bus.RSTCF      = s.rstcf;
    bus.RSTDF      = s.rstdf;
    bus.RSTIF      = s.rstif;
    bus.SETCF      = s.setcf;
    bus.SETDF      = s.setdf;
    bus.SETIF      = s.setif;
    bus.TOGCF      = s.togcf;
    bus.alu_we     = s.alu_we;
    bus.alu_mask   = s.alu_mask;
    bus.alu_flags  = s.alu_flags;
    bus.sahf_we    = s.sahf_we;
    bus.ah_in      = s.ah;
    bus.popf_we    = s.popf_we;
    bus.popf_data  = s.popf_data;
    bus.int_ack    = s.int_ack;
    bus.instr_done = s.instr_done;
    if (!rst) begin
      m_flags  = 16'hF002;
      m_shadow = 0;
      m_armed  = 0;
    end
    e.flags = m_flags;
    e.ie    = m_flags[9] && !m_shadow;
    e.trap  = s.instr_done && m_armed;
    exp_q.push_back(e);
    if (rst) begin
      nf = model_next(s, m_flags);
`ifdef FLAGS_STI_SHADOW_EN
      if (!m_shadow)
        nshadow = s.setif && !s.int_ack && !s.popf_we && !m_flags[9];
      else
        nshadow = !(s.instr_done || s.rstif || s.int_ack || s.popf_we);
`else
      nshadow = 0;
`endif
      narmed   = s.int_ack ? 1'b0 : (s.instr_done ? m_flags[8] : m_armed);
      m_flags  = nf;
      m_shadow = nshadow;
      m_armed  = narmed;
    end
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("flags", bus.flags, e.flags);
      check("int_enable", {15'd0, bus.int_enable}, {15'd0, e.ie});
      check("trap_req", {15'd0, bus.trap_req}, {15'd0, e.trap});
    end
  end

  function automatic stim_t rand_stim();
    stim_t s;
    s = '0;
    case ($urandom_range(0, 13))
      0: s.rstcf = 1'b1;
      1: s.rstdf = 1'b1;
      2: s.rstif = 1'b1;
      3: s.setcf = 1'b1;
      4: s.setdf = 1'b1;
      5: s.setif = 1'b1;
      6: s.togcf = 1'b1;
      default: ;
    endcase
    s.alu_we     = ($urandom_range(0, 2) == 0);
    s.alu_mask   = 6'($urandom);
    s.alu_flags  = 6'($urandom);
    s.sahf_we    = ($urandom_range(0, 9) == 0);
    s.ah         = 8'($urandom);
    s.popf_we    = ($urandom_range(0, 11) == 0);
    s.popf_data  = 16'($urandom);
    s.int_ack    = ($urandom_range(0, 19) == 0);
    s.instr_done = ($urandom_range(0, 2) == 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    {bus.RSTCF, bus.RSTDF, bus.RSTIF, bus.SETCF, bus.SETDF, bus.SETIF, bus.TOGCF} = '0;
    bus.alu_we = 0; bus.alu_mask = '0; bus.alu_flags = '0;
    bus.sahf_we = 0; bus.ah_in = '0; bus.popf_we = 0; bus.popf_data = '0;
    bus.int_ack = 0; bus.instr_done = 0;
    m_flags = 16'hF002; m_shadow = 0; m_armed = 0;

    // Reset, then POPF 0FFF.
    apply(z(), 0);
    apply(z(), 0);
    s = z(); s.popf_we = 1; s.popf_data = 16'h0FFF; apply(s, 1);
    apply(z(), 1);
    // CF ops: STC, CMC, CMC with ALU CF write.
    s = z(); s.setcf = 1; apply(s, 1);
    s = z(); s.togcf = 1; apply(s, 1);
    s = z(); s.togcf = 1; s.alu_we = 1; s.alu_mask = 6'b000001; s.alu_flags = 6'b000001;
    apply(s, 1);
    apply(z(), 1);
    // Priority: POPF beats SAHF and STD.
    s = z(); s.popf_we = 1; s.popf_data = 16'h0000; s.setdf = 1; s.sahf_we = 1; s.ah = 8'hFF;
    apply(s, 1);
    apply(z(), 1);
    // STI shadow released by a later boundary.
    s = z(); s.setif = 1; apply(s, 1);
    apply(z(), 1);
    s = z(); s.instr_done = 1; apply(s, 1);
    apply(z(), 1);
    apply(z(), 1);
    // Shadow cancelled by CLI; boundary in the entry cycle is ignored.
    s = z(); s.rstif = 1; apply(s, 1);
    s = z(); s.setif = 1; s.instr_done = 1; apply(s, 1);
    apply(z(), 1);
    s = z(); s.rstif = 1; apply(s, 1);
    s = z(); s.instr_done = 1; apply(s, 1);
    apply(z(), 1);
    // Shared flags: ALU CF and CLD together.
    s = z(); s.rstdf = 1; s.alu_we = 1; s.alu_mask = 6'b100001; s.alu_flags = 6'b100001;
    apply(s, 1);
    // Single-step: TF set, three boundaries, then int_ack.
    s = z(); s.popf_we = 1; s.popf_data = 16'h0300; apply(s, 1);
    for (int k = 0; k < 3; k++) begin
      s = z(); s.instr_done = 1; apply(s, 1);
      apply(z(), 1);
    end
    s = z(); s.int_ack = 1; apply(s, 1);
    s = z(); s.instr_done = 1; apply(s, 1);
    apply(z(), 1);
    // Mid-operation asynchronous reset.
    s = z(); s.popf_we = 1; s.popf_data = 16'hFFFF; apply(s, 1);
    apply(z(), 1);
    apply(z(), 0);
    apply(z(), 1);

    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) apply(z(), 0);
      else apply(rand_stim(), 1);
    end
    apply(z(), 1);

    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
